// File: rtl/frankie_pkg.sv
// Shared encodings for the Frankie control-unit / memory-port interface.
// Holds the MemDst/MemSrc codes, the responder FSM states and the request-legality helper.
// No storage and no flow control; constants and pure functions only.
package frankie_pkg;

    // Address select codes (MemDst)
    localparam logic [2:0] DST_PC      = 3'b000;
    localparam logic [2:0] DST_IMM     = 3'b001;
    localparam logic [2:0] DST_SHELLEY = 3'b011;
    localparam logic [2:0] DST_PUSH    = 3'b100;
    localparam logic [2:0] DST_PEEK    = 3'b101;
    localparam logic [2:0] DST_POP     = 3'b110;

    // Write data select codes (MemSrc)
    localparam logic [1:0] SRC_MARY    = 2'b00;
    localparam logic [1:0] SRC_SHELLEY = 2'b01;
    localparam logic [1:0] SRC_RA      = 2'b10;
    localparam logic [1:0] SRC_IMM     = 2'b11;

    // Responder FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Encoding-level legality only; stack bounds depend on SP and are checked by the caller.
    // PC and the peek/pop slots are read-only, push is write-only, 010/111 are unassigned.
    function automatic logic dst_illegal(input logic [2:0] dst, input logic we);
        logic bad;
        case (dst)
            DST_PC, DST_PEEK, DST_POP: bad = we;
            DST_PUSH:                  bad = !we;
            DST_IMM, DST_SHELLEY:      bad = 1'b0;
            default:                   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_req_timer.sv
// Counts cycles spent waiting in REQ and flags the last permitted cycle.
// expired is combinational from the count; the count clears on the cycle before REQ is entered.
// No backpressure; it only observes run/clear.
module mem_req_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Count REQ cycles; restarting from zero each time a new request is launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 1'b1;
        end
    end

    // First REQ cycle sees cnt=0, so the TIMEOUT-th REQ cycle is the last one allowed.
    assign expired = run && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_responder.sv
// Memory-strobe responder: latches a control-unit request, runs one req/ack RAM transaction, reports done/fault/timeout.
// Latency: MemStart in cycle t -> MemDone in t+2 with a zero-wait RAM; illegal requests finish at t+1 without touching RAM.
// Backpressure: MemBusy stalls the control unit from MemStart until the DONE cycle; MemStart outside IDLE is ignored.
module mem_port_responder
    import frankie_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter int                IMM_W       = 11,
    parameter logic [DATA_W-1:0] STACK_BASE  = 16'hFFFE,
    parameter logic [DATA_W-1:0] STACK_LIMIT = 16'hF000,
    parameter int                TIMEOUT     = 15
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemStart,
    input  logic              MemWrite,
    input  logic [2:0]        MemDst,
    input  logic [1:0]        MemSrc,
    input  logic [DATA_W-1:0] PC,
    input  logic [DATA_W-1:0] Shelley,
    input  logic [DATA_W-1:0] Mary,
    input  logic [DATA_W-1:0] RA,
    input  logic [DATA_W-1:0] SP,
    input  logic [IMM_W-1:0]  Imm,
    output logic              MemBusy,
    output logic              MemDone,
    output logic [DATA_W-1:0] MemData,
    output logic              MemFault,
    output logic              MemTimeout,
    output logic              ram_req,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack
);
    logic [1:0]        state;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W:0]   push_ext;
    logic [DATA_W-1:0] push_addr;
    logic [DATA_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              illegal;
    logic              accept;
    logic              timer_expired;

    assign imm_ext   = {{(DATA_W - IMM_W){1'b0}}, Imm};
    // One extra bit keeps the borrow of SP-1, so SP=0 is seen as below the limit rather than wrapping to the top.
    assign push_ext  = {1'b0, SP} - {{DATA_W{1'b0}}, 1'b1};
    assign push_addr = push_ext[DATA_W-1:0];
    assign accept    = (state == ST_IDLE) && MemStart;

    // Address select from the architectural registers.
    always_comb begin
        addr_sel = '0;
        case (MemDst)
            DST_PC:            addr_sel = PC;
            DST_IMM:           addr_sel = imm_ext;
            DST_SHELLEY:       addr_sel = Shelley;
            DST_PUSH:          addr_sel = push_addr;
            DST_PEEK, DST_POP: addr_sel = SP;
            default:           addr_sel = '0;
        endcase
    end

    // Write data select.
    always_comb begin
        wdata_sel = Mary;
        case (MemSrc)
            SRC_MARY:    wdata_sel = Mary;
            SRC_SHELLEY: wdata_sel = Shelley;
            SRC_RA:      wdata_sel = RA;
            SRC_IMM:     wdata_sel = imm_ext;
            default:     wdata_sel = Mary;
        endcase
    end

    // Illegal encodings plus stack overflow (push below limit) and underflow (peek/pop of an empty stack).
    always_comb begin
        illegal = dst_illegal(MemDst, MemWrite);
        if (MemDst == DST_PUSH && (push_ext[DATA_W] || push_addr < STACK_LIMIT)) begin
            illegal = 1'b1;
        end
        if ((MemDst == DST_PEEK || MemDst == DST_POP) && SP >= STACK_BASE) begin
            illegal = 1'b1;
        end
    end

    // Stall while a request is being taken or is outstanding; released in DONE so the
    // control unit advances on the edge that returns us to IDLE.
    assign MemBusy = accept || (state == ST_REQ);

    mem_req_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (CLK),
        .rst_n   (Reset),
        .clear   (accept && !illegal),
        .run     (state == ST_REQ),
        .expired (timer_expired)
    );

    // Transaction FSM and all registered outputs.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            MemDone    <= 1'b0;
            MemData    <= '0;
            MemFault   <= 1'b0;
            MemTimeout <= 1'b0;
            ram_req    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            MemDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (MemStart) begin
                        if (illegal) begin
                            state    <= ST_DONE;
                            MemFault <= 1'b1;
                            MemDone  <= 1'b1;
                        end else begin
                            state     <= ST_REQ;
                            ram_req   <= 1'b1;
                            ram_we    <= MemWrite;
                            ram_addr  <= addr_sel;
                            ram_wdata <= wdata_sel;
                        end
                    end
                end
                ST_REQ: begin
                    // An ack on the last permitted cycle still completes normally.
                    if (ram_ack) begin
                        if (!ram_we) begin
                            MemData <= ram_rdata;
                        end
                        ram_req <= 1'b0;
                        state   <= ST_DONE;
                        MemDone <= 1'b1;
                    end else if (timer_expired) begin
                        MemTimeout <= 1'b1;
                        MemData    <= '0;
                        ram_req    <= 1'b0;
                        state      <= ST_DONE;
                        MemDone    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    ram_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed bench for mem_port_responder: inputs driven and outputs sampled just after the falling edge.
module tb_mem_port_responder;
    logic        CLK = 1'b0;
    logic        Reset;
    logic        MemStart;
    logic        MemWrite;
    logic [2:0]  MemDst;
    logic [1:0]  MemSrc;
    logic [15:0] PC, Shelley, Mary, RA, SP;
    logic [10:0] Imm;
    logic        MemBusy, MemDone, MemFault, MemTimeout;
    logic [15:0] MemData;
    logic        ram_req, ram_we;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_ack;

    int total = 0;
    int bad   = 0;
    int nreq;

    always #5 CLK = ~CLK;

    mem_port_responder dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .MemStart   (MemStart),
        .MemWrite   (MemWrite),
        .MemDst     (MemDst),
        .MemSrc     (MemSrc),
        .PC         (PC),
        .Shelley    (Shelley),
        .Mary       (Mary),
        .RA         (RA),
        .SP         (SP),
        .Imm        (Imm),
        .MemBusy    (MemBusy),
        .MemDone    (MemDone),
        .MemData    (MemData),
        .MemFault   (MemFault),
        .MemTimeout (MemTimeout),
        .ram_req    (ram_req),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .ram_ack    (ram_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next falling edge.
    task automatic nclk();
        @(negedge CLK);
        #1;
    endtask

    task automatic start(input logic we, input logic [2:0] dst, input logic [1:0] src);
        MemWrite = we;
        MemDst   = dst;
        MemSrc   = src;
        MemStart = 1'b1;
    endtask

    initial begin
        Reset = 1'b0; MemStart = 1'b0; MemWrite = 1'b0; MemDst = 3'b000; MemSrc = 2'b00;
        PC = '0; Shelley = '0; Mary = '0; RA = '0; SP = 16'hFFFE; Imm = '0;
        ram_rdata = '0; ram_ack = 1'b0;

        // Reset state
        nclk(); nclk();
        chk("rst_done", MemDone, 0);
        chk("rst_data", MemData, 0);
        chk("rst_fault", MemFault, 0);
        chk("rst_tmo", MemTimeout, 0);
        chk("rst_req", ram_req, 0);
        chk("rst_busy", MemBusy, 0);
        Reset = 1'b1;
        nclk();

        // 1: read PC, zero-wait ack
        PC = 16'h0040; start(1'b0, 3'b000, 2'b00); #1;
        chk("t1_busy_start", MemBusy, 1);
        nclk(); MemStart = 1'b0; #1;
        chk("t1_req", ram_req, 1);
        chk("t1_addr", ram_addr, 16'h0040);
        chk("t1_we", ram_we, 0);
        chk("t1_done_early", MemDone, 0);
        ram_ack = 1'b1; ram_rdata = 16'h3A05;
        nclk(); ram_ack = 1'b0; #1;
        chk("t1_done", MemDone, 1);
        chk("t1_data", MemData, 16'h3A05);
        chk("t1_busy_done", MemBusy, 0);
        chk("t1_req_drop", ram_req, 0);
        nclk();
        chk("t1_done_pulse", MemDone, 0);

        // 2: push RA at SP=FFFE
        SP = 16'hFFFE; RA = 16'h0123; start(1'b1, 3'b100, 2'b10);
        nclk(); MemStart = 1'b0; #1;
        chk("t2_req", ram_req, 1);
        chk("t2_we", ram_we, 1);
        chk("t2_addr", ram_addr, 16'hFFFD);
        chk("t2_wdata", ram_wdata, 16'h0123);
        chk("t2_fault", MemFault, 0);
        ram_ack = 1'b1; ram_rdata = 16'h9999;
        nclk(); ram_ack = 1'b0; #1;
        chk("t2_done", MemDone, 1);
        chk("t2_data_kept", MemData, 16'h3A05);
        nclk();

        // 6: MemStart pulses during REQ and DONE are ignored
        Shelley = 16'h1234; start(1'b0, 3'b011, 2'b00);
        nclk(); MemStart = 1'b1; MemDst = 3'b000; #1;
        chk("t6_addr", ram_addr, 16'h1234);
        chk("t6_busy_req", MemBusy, 1);
        nclk(); MemStart = 1'b0; ram_ack = 1'b1; ram_rdata = 16'hBEEF; #1;
        chk("t6_req_held", ram_req, 1);
        chk("t6_addr_held", ram_addr, 16'h1234);
        nclk(); ram_ack = 1'b0; MemStart = 1'b1; #1;
        chk("t6_done", MemDone, 1);
        chk("t6_data", MemData, 16'hBEEF);
        chk("t6_busy_done", MemBusy, 0);
        nclk(); MemStart = 1'b0; #1;
        chk("t6_no_req_a", ram_req, 0);
        chk("t6_done_once", MemDone, 0);
        nclk();
        chk("t6_no_req_b", ram_req, 0);
        chk("t6_fault", MemFault, 0);

        // 3: pop from an empty stack faults without touching RAM
        SP = 16'hFFFE; start(1'b0, 3'b110, 2'b00);
        nclk(); MemStart = 1'b0; #1;
        chk("t3_done", MemDone, 1);
        chk("t3_fault", MemFault, 1);
        chk("t3_no_req", ram_req, 0);
        chk("t3_data_kept", MemData, 16'hBEEF);
        nclk();
        chk("t3_done_pulse", MemDone, 0);

        // 4: RAM never acks
        PC = 16'h0100; start(1'b0, 3'b000, 2'b00);
        nclk(); MemStart = 1'b0; #1;
        nreq = 0;
        for (int i = 0; i < 40 && !MemDone; i++) begin
            if (ram_req) nreq++;
            nclk();
        end
        chk("t4_req_cycles", nreq, 15);
        chk("t4_done", MemDone, 1);
        chk("t4_timeout", MemTimeout, 1);
        chk("t4_data_zero", MemData, 0);
        chk("t4_req_drop", ram_req, 0);
        nclk();

        // 5: async reset in the middle of REQ
        PC = 16'h0200; start(1'b0, 3'b000, 2'b00);
        nclk(); MemStart = 1'b0; #1;
        chk("t5_req", ram_req, 1);
        #1 Reset = 1'b0; #1;
        chk("t5_req_async", ram_req, 0);
        chk("t5_tmo_clr", MemTimeout, 0);
        chk("t5_fault_clr", MemFault, 0);
        nclk(); Reset = 1'b1; #1;
        Imm = 11'h7FF; start(1'b0, 3'b001, 2'b00);
        nclk(); MemStart = 1'b0; #1;
        chk("t5_req_again", ram_req, 1);
        chk("t5_imm_addr", ram_addr, 16'h07FF);
        ram_ack = 1'b1; ram_rdata = 16'h5555;
        nclk(); ram_ack = 1'b0; #1;
        chk("t5_done", MemDone, 1);
        chk("t5_data", MemData, 16'h5555);
        nclk();

        // ram_ack while idle is ignored
        ram_ack = 1'b1; ram_rdata = 16'hFFFF;
        nclk(); ram_ack = 1'b0; #1;
        chk("idle_ack_data", MemData, 16'h5555);
        chk("idle_ack_done", MemDone, 0);

        // Write Mary to the Shelley address
        Shelley = 16'h0800; Mary = 16'hCAFE; start(1'b1, 3'b011, 2'b00);
        nclk(); MemStart = 1'b0; #1;
        chk("wr_addr", ram_addr, 16'h0800);
        chk("wr_wdata", ram_wdata, 16'hCAFE);
        chk("wr_we", ram_we, 1);
        chk("wr_fault", MemFault, 0);
        ram_ack = 1'b1;
        nclk(); ram_ack = 1'b0; #1;
        nclk();

        // Push at SP=0: borrow is caught by the limit check
        SP = 16'h0000; start(1'b1, 3'b100, 2'b01);
        nclk(); MemStart = 1'b0; #1;
        chk("wrap_fault", MemFault, 1);
        chk("wrap_done", MemDone, 1);
        chk("wrap_no_req", ram_req, 0);
        nclk();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
